// File: rtl/gsm_pkg.sv
// Shared definitions for the GSM alarm path: FSM states, message id width and the
// default system clock frequency also used by the threshold/hold-timer logic.
package gsm_pkg;

    localparam int unsigned CLK_HZ_DEF = 32'd24_000_000;
    localparam int unsigned ID_W       = 32'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_e;

    // Width of a counter that must hold values 0..v-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned v);
        if (v <= 32'd1) begin
            return 32'd1;
        end else begin
            return $clog2(v);
        end
    endfunction

endpackage

// File: rtl/sec_tick.sv
// One-second prescaler with synchronous clear, seconds counter and a match flag
// that fires on the last cycle of the target-th second.
module sec_tick
    import gsm_pkg::*;
#(
    parameter int unsigned CLK_HZ = CLK_HZ_DEF,
    parameter int unsigned SEC_W  = 32'd4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [SEC_W-1:0] target,
    output logic             tick,
    output logic             match
);

    localparam int unsigned      PRE_W   = cnt_width(CLK_HZ);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 32'd1);

    logic [PRE_W-1:0] pre_r;
    logic [SEC_W-1:0] sec_r;

    assign tick  = (pre_r == PRE_MAX);
    assign match = tick && (sec_r == (target - SEC_W'(1'b1)));

    // Prescaler and seconds counter; clear restarts the interval from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_r <= '0;
            sec_r <= '0;
        end else if (clr) begin
            pre_r <= '0;
            sec_r <= '0;
        end else if (tick) begin
            pre_r <= '0;
            sec_r <= sec_r + SEC_W'(1'b1);
        end else begin
            pre_r <= pre_r + PRE_W'(1'b1);
        end
    end

endmodule

// File: rtl/gsm_msg_sched.sv
// Round-robin scheduler sharing one GSM SMS sender between up to four alarm
// sources, with timeout, bounded retries and a cooldown gap after every attempt.
module gsm_msg_sched
    import gsm_pkg::*;
#(
    parameter int unsigned N_REQ     = 32'd4,
    parameter int unsigned CLK_HZ    = CLK_HZ_DEF,
    parameter int unsigned GAP_S     = 32'd4,
    parameter int unsigned TIMEOUT_S = 32'd10,
    parameter int unsigned MAX_RETRY = 32'd2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_pulse,
    input  logic             send_done,
    input  logic             send_err,
    output logic             send_start,
    output logic [ID_W-1:0]  send_id,
    output logic [N_REQ-1:0] pending,
    output logic             fail_pulse,
    output logic [ID_W-1:0]  fail_id,
    output logic             led_n
);

    localparam int unsigned SEC_MAX = (GAP_S > TIMEOUT_S) ? GAP_S : TIMEOUT_S;
    localparam int unsigned SEC_W   = cnt_width(SEC_MAX + 32'd1);
    localparam int unsigned RC_W    = cnt_width(MAX_RETRY + 32'd1);

    state_e             state_r, state_nxt;
    logic [ID_W-1:0]    send_id_r, send_id_nxt;
    logic [N_REQ-1:0]   pending_r, pending_nxt, clr_mask_s;
    logic               send_start_r, send_start_nxt;
    logic               fail_pulse_r, fail_pulse_nxt;
    logic [ID_W-1:0]    fail_id_r, fail_id_nxt;
    logic               led_n_r, led_n_nxt;
    logic [RC_W-1:0]    retry_cnt_r, retry_cnt_nxt;
    logic               retry_r, retry_nxt;
    logic [ID_W-1:0]    last_grant_r, last_grant_nxt;
    logic [ID_W-1:0]    grant_s;
    logic [SEC_W-1:0]   target_s;
    logic               tmr_clr_s, tick_s, match_s;

    sec_tick #(
        .CLK_HZ (CLK_HZ),
        .SEC_W  (SEC_W)
    ) u_sec_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr_s),
        .target (target_s),
        .tick   (tick_s),
        .match  (match_s)
    );

    // Round-robin pick: scan downward so the offset closest to last_grant+1 wins.
    always_comb begin
        grant_s = last_grant_r;
        for (int i = N_REQ; i >= 1; i--) begin
            if (pending_r[(int'(last_grant_r) + i) % N_REQ]) begin
                grant_s = ID_W'((int'(last_grant_r) + i) % N_REQ);
            end else begin
                grant_s = grant_s;
            end
        end
    end

    // Interval length depends on whether we are cooling down or awaiting the sender.
    always_comb begin
        if (state_r == GAP) begin
            target_s = SEC_W'(GAP_S);
        end else begin
            target_s = SEC_W'(TIMEOUT_S);
        end
    end

    // Scheduler next-state logic; every output is computed here and registered below.
    always_comb begin
        state_nxt      = state_r;
        send_id_nxt    = send_id_r;
        send_start_nxt = 1'b0;
        fail_pulse_nxt = 1'b0;
        fail_id_nxt    = fail_id_r;
        retry_cnt_nxt  = retry_cnt_r;
        retry_nxt      = retry_r;
        last_grant_nxt = last_grant_r;
        clr_mask_s     = '0;
        case (state_r)
            IDLE: begin
                if (|pending_r) begin
                    send_id_nxt    = grant_s;
                    clr_mask_s     = N_REQ'(1'b1) << grant_s;
                    retry_cnt_nxt  = '0;
                    send_start_nxt = 1'b1;
                    state_nxt      = START;
                end else begin
                    state_nxt = IDLE;
                end
            end
            START: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (send_done) begin
                    retry_nxt = 1'b0;
                    state_nxt = GAP;
                end else if (send_err || match_s) begin
                    if (retry_cnt_r < RC_W'(MAX_RETRY)) begin
                        retry_cnt_nxt = retry_cnt_r + RC_W'(1'b1);
                        retry_nxt     = 1'b1;
                    end else begin
                        fail_pulse_nxt = 1'b1;
                        fail_id_nxt    = send_id_r;
                        retry_nxt      = 1'b0;
                    end
                    state_nxt = GAP;
                end else begin
                    state_nxt = WAIT;
                end
            end
            GAP: begin
                if (match_s) begin
                    if (retry_r) begin
                        send_start_nxt = 1'b1;
                        state_nxt      = START;
                    end else begin
                        last_grant_nxt = send_id_r;
                        state_nxt      = IDLE;
                    end
                end else begin
                    state_nxt = GAP;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // A new request arriving on its own grant cycle survives the clear.
        pending_nxt = (pending_r & ~clr_mask_s) | req_pulse;
        led_n_nxt   = !((state_nxt != IDLE) || (|pending_nxt));
        tmr_clr_s   = (state_nxt != state_r);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            send_id_r    <= '0;
            pending_r    <= '0;
            send_start_r <= 1'b0;
            fail_pulse_r <= 1'b0;
            fail_id_r    <= '0;
            led_n_r      <= 1'b1;
            retry_cnt_r  <= '0;
            retry_r      <= 1'b0;
            last_grant_r <= ID_W'(N_REQ - 32'd1);
        end else begin
            state_r      <= state_nxt;
            send_id_r    <= send_id_nxt;
            pending_r    <= pending_nxt;
            send_start_r <= send_start_nxt;
            fail_pulse_r <= fail_pulse_nxt;
            fail_id_r    <= fail_id_nxt;
            led_n_r      <= led_n_nxt;
            retry_cnt_r  <= retry_cnt_nxt;
            retry_r      <= retry_nxt;
            last_grant_r <= last_grant_nxt;
        end
    end

    assign send_start = send_start_r;
    assign send_id    = send_id_r;
    assign pending    = pending_r;
    assign fail_pulse = fail_pulse_r;
    assign fail_id    = fail_id_r;
    assign led_n      = led_n_r;

endmodule

// File: tb/tb_gsm_msg_sched.sv
// Scoreboard bench for gsm_msg_sched: expected starts/drops are queued with their
// cycle when stimulus is applied and compared as the DUT emits pulses.
module tb_gsm_msg_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_pulse;
    logic       send_done;
    logic       send_err;
    logic       send_start;
    logic [1:0] send_id;
    logic [3:0] pending;
    logic       fail_pulse;
    logic [1:0] fail_id;
    logic       led_n;

    typedef struct { int kind; int id; int cyc; } ev_t;   // kind 0 start, 1 drop
    typedef struct { int kind; int dly; } resp_t;         // kind 0 done, 1 err, 2 silent

    ev_t   exp_q[$];
    resp_t resp_q[$];
    int    cyc = 0;
    int    n_chk = 0;
    int    n_pass = 0;
    int    c0, s1, s2, s3;

    gsm_msg_sched #(
        .N_REQ     (4),
        .CLK_HZ    (10),
        .GAP_S     (2),
        .TIMEOUT_S (3),
        .MAX_RETRY (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_pulse  (req_pulse),
        .send_done  (send_done),
        .send_err   (send_err),
        .send_start (send_start),
        .send_id    (send_id),
        .pending    (pending),
        .fail_pulse (fail_pulse),
        .fail_id    (fail_id),
        .led_n      (led_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic exp_start(input int id, input int c);
        ev_t e;
        e.kind = 0; e.id = id; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic exp_drop(input int id, input int c);
        ev_t e;
        e.kind = 1; e.id = id; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic add_resp(input int kind, input int dly);
        resp_t r;
        r.kind = kind; r.dly = dly;
        resp_q.push_back(r);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_req(input logic [3:0] m);
        req_pulse = m;
        @(posedge clk); #1;
        req_pulse = 4'b0000;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (exp_q.size() != 0 || led_n !== 1'b1); i++) begin
            @(posedge clk); #1;
        end
        check_eq("drain_queue", exp_q.size(), 0);
        check_eq("drain_idle", led_n, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_send_start"}, send_start, 0);
        check_eq({tag, "_send_id"}, send_id, 0);
        check_eq({tag, "_pending"}, pending, 0);
        check_eq({tag, "_fail_pulse"}, fail_pulse, 0);
        check_eq({tag, "_fail_id"}, fail_id, 0);
        check_eq({tag, "_led_n"}, led_n, 1);
    endtask

    // Scoreboard: every start/drop pulse must match the head of the queue.
    always @(negedge clk) begin
        ev_t e;
        if (rst_n === 1'b1) begin
            if (send_start === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check_eq("start_unexpected", send_start, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("start_kind", e.kind, 0);
                    check_eq("start_id", send_id, e.id);
                    check_eq("start_cycle", cyc, e.cyc);
                end
            end
            if (fail_pulse === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check_eq("drop_unexpected", fail_pulse, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("drop_kind", e.kind, 1);
                    check_eq("drop_id", fail_id, e.id);
                    check_eq("drop_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Sender model: answers each start per the response queue.
    initial begin
        resp_t r;
        send_done = 1'b0;
        send_err  = 1'b0;
        forever begin
            @(negedge clk);
            if (send_start === 1'b1 && resp_q.size() > 0) begin
                r = resp_q.pop_front();
                if (r.kind != 2) begin
                    repeat (r.dly) @(posedge clk);
                    #1;
                    if (r.kind == 0) send_done = 1'b1;
                    else             send_err  = 1'b1;
                    @(posedge clk); #1;
                    send_done = 1'b0;
                    send_err  = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_pulse = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Round-robin from reset: 0, 1, 3
        c0 = cyc;
        exp_start(0, c0 + 2);  exp_start(1, c0 + 29); exp_start(3, c0 + 56);
        repeat (3) add_resp(0, 5);
        pulse_req(4'b1011);
        @(negedge clk);
        check_eq("rr_pending_latched", pending, 4'b1011);
        goto(c0 + 2);
        @(negedge clk);
        check_eq("rr_pending_after_grant", pending, 4'b1010);
        drain(200);

        // After id 3 the pointer wraps back to 0
        c0 = cyc;
        exp_start(0, c0 + 2);  exp_start(1, c0 + 29);
        repeat (2) add_resp(0, 5);
        pulse_req(4'b0011);
        drain(200);

        // Single request on source 1, done after 5 cycles, 20-cycle gap
        c0 = cyc;
        s1 = c0 + 2;
        exp_start(1, s1);
        add_resp(0, 5);
        pulse_req(4'b0010);
        @(negedge clk);
        check_eq("single_pending", pending, 4'b0010);
        check_eq("single_busy", led_n, 0);
        goto(s1 + 25);
        @(negedge clk);
        check_eq("single_gap_last", led_n, 0);
        goto(s1 + 26);
        @(negedge clk);
        check_eq("single_idle", led_n, 1);
        drain(100);

        // Silent sender: three attempts on id 2 then a drop
        c0 = cyc;
        s1 = c0 + 2; s2 = s1 + 51; s3 = s2 + 51;
        exp_start(2, s1); exp_start(2, s2); exp_start(2, s3);
        exp_drop(2, s3 + 31);
        repeat (3) add_resp(2, 0);
        pulse_req(4'b0100);
        goto(s3 + 50);
        @(negedge clk);
        check_eq("timeout_gap_last", led_n, 0);
        goto(s3 + 51);
        @(negedge clk);
        check_eq("timeout_idle", led_n, 1);
        drain(400);

        // Error then success on id 3: one re-send, no drop
        c0 = cyc;
        s1 = c0 + 2;
        exp_start(3, s1); exp_start(3, s1 + 25);
        add_resp(1, 4); add_resp(0, 5);
        pulse_req(4'b1000);
        drain(200);
        check_eq("retry_fail_id_held", fail_id, 2);

        // Coalescing while in WAIT plus a request on the grant cycle
        c0 = cyc;
        s1 = c0 + 2; s2 = s1 + 27; s3 = s2 + 27;
        exp_start(2, s1); exp_start(2, s2); exp_start(2, s3);
        repeat (3) add_resp(0, 5);
        pulse_req(4'b0100);
        goto(s1 + 1);
        repeat (3) pulse_req(4'b0100);
        @(negedge clk);
        check_eq("coalesce_pending", pending, 4'b0100);
        goto(s1 + 26);
        pulse_req(4'b0100);
        @(negedge clk);
        check_eq("collision_pending", pending, 4'b0100);
        drain(300);

        // Reset while waiting on the sender
        c0 = cyc;
        s1 = c0 + 2;
        exp_start(1, s1);
        add_resp(2, 0);
        pulse_req(4'b0010);
        goto(s1 + 5);
        pulse_req(4'b1000);
        goto(s1 + 10);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        exp_start(0, c0 + 2); exp_start(1, c0 + 29);
        repeat (2) add_resp(0, 5);
        pulse_req(4'b0011);
        drain(200);
        check_eq("resp_queue_empty", resp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
